// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a bank of 8-bit registers.
// The master writes a register pointer, then data bytes that auto-increment
// the pointer. A repeated START with R/W=1 reads back from the current pointer.
// A local read port gives the rest of the chip combinational access to the bank.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic [3:0]    r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_ptr;
    logic          r_rw;
    logic          r_ack_on;
    logic          r_mnack;
    logic          r_sda_oe;
    logic          r_wr_strobe;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_busy;
    logic [7:0]    r_regs [DEPTH];

    logic          w_scl;
    logic          w_sda;
    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic [7:0]    w_byte;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high on both sides of the SDA edge so that an SDA change
    // racing an SCL fall through the synchronisers is never taken as START/STOP.
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    // Byte as it stands once the bit on the current SCL rise is shifted in.
    assign w_byte     = {r_shift[6:0], w_sda};

    assign sda_oe    = r_sda_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign rd_data   = r_regs[rd_addr];

    // Synchronise the bus lines and keep one cycle of history for edge detection.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the chain shifts one stage per clock.
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    // Protocol FSM, pointer, register bank and write strobe.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_ack_on    <= 1'b0;
            r_mnack     <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_busy      <= 1'b0;
            // NOTE: the bank is reset explicitly because the local read port
            // must show 00 after reset; this keeps it in flops, not RAM.
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_stop) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_ack_on  <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_ADDR;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_ack_on  <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= ST_ADDR_ACK;
                                end else begin
                                    r_state <= ST_IGNORE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                                r_busy   <= 1'b1;
                            end else begin
                                r_ack_on <= 1'b0;
                                if (r_rw) begin
                                    // First read bit goes out on this same fall.
                                    r_state  <= ST_RDATA;
                                    r_shift  <= r_regs[r_ptr];
                                    r_sda_oe <= ~r_regs[r_ptr][7];
                                end else begin
                                    r_state  <= ST_PTR;
                                    r_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_ptr     <= w_byte[AW-1:0];
                                r_state   <= ST_PTR_ACK;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt     <= 4'd0;
                                r_regs[r_ptr] <= w_byte;
                                r_wr_strobe   <= 1'b1;
                                r_wr_addr     <= r_ptr;
                                r_wr_data     <= w_byte;
                                r_ptr         <= r_ptr + AW'(1);
                                r_state       <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_ack_on <= 1'b0;
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_bit_cnt <= 4'd0;
                                r_sda_oe  <= 1'b0;
                                r_ptr     <= r_ptr + AW'(1);
                                r_state   <= ST_RDATA_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[6];
                                r_shift  <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mnack <= w_sda;
                        end else if (w_scl_fall) begin
                            if (r_mnack) begin
                                r_state  <= ST_IGNORE;
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_state  <= ST_RDATA;
                                r_shift  <= r_regs[r_ptr];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
